// File: rtl/dma_psdp_ram_seg_pkg.sv
// Shared widths and address helpers for the segmented DMA RAM and the DMA
// engines that address it.
package dma_ram_pkg;

    localparam int DEF_SEG_COUNT      = 2;
    localparam int DEF_SEG_DATA_WIDTH = 256;
    localparam int DEF_SEG_ADDR_WIDTH = 12;
    localparam int DEF_SEG_BE_WIDTH   = DEF_SEG_DATA_WIDTH / 8;

    // Byte address width of the whole segmented RAM as seen by the DMA engines:
    // word address, segment select and byte-within-segment offset.
    function automatic int ram_addr_width(input int seg_addr_width,
                                          input int seg_count,
                                          input int seg_be_width);
        return seg_addr_width + $clog2(seg_count) + $clog2(seg_be_width);
    endfunction

endpackage

// File: rtl/dma_psdp_ram_seg_if.sv
// Bundled write-command / read-command / read-response buses of the segmented
// DMA RAM. All buses are flat concatenations, segment n in slice n.
interface dma_psdp_ram_seg_if
    import dma_ram_pkg::*;
#(
    parameter int SEG_COUNT      = DEF_SEG_COUNT,
    parameter int SEG_DATA_WIDTH = DEF_SEG_DATA_WIDTH,
    parameter int SEG_ADDR_WIDTH = DEF_SEG_ADDR_WIDTH,
    parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8
) ();

    logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be;
    logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr;
    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data;
    logic [SEG_COUNT-1:0]                wr_cmd_valid;
    logic [SEG_COUNT-1:0]                wr_cmd_ready;
    logic [SEG_COUNT-1:0]                wr_done;

    logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr;
    logic [SEG_COUNT-1:0]                rd_cmd_valid;
    logic [SEG_COUNT-1:0]                rd_cmd_ready;
    logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data;
    logic [SEG_COUNT-1:0]                rd_resp_valid;
    logic [SEG_COUNT-1:0]                rd_resp_ready;

    // DMA engine / application side
    modport master (
        output wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid,
        input  wr_cmd_ready, wr_done,
        output rd_cmd_addr, rd_cmd_valid,
        input  rd_cmd_ready,
        input  rd_resp_data, rd_resp_valid,
        output rd_resp_ready
    );

    // RAM side
    modport slave (
        input  wr_cmd_be, wr_cmd_addr, wr_cmd_data, wr_cmd_valid,
        output wr_cmd_ready, wr_done,
        input  rd_cmd_addr, rd_cmd_valid,
        output rd_cmd_ready,
        output rd_resp_data, rd_resp_valid,
        input  rd_resp_ready
    );

endinterface

// File: rtl/dma_psdp_ram_seg_bank.sv
// One segment of the DMA RAM: byte-enabled SRAM array, write-done pulse and
// an elastic read pipeline of PIPELINE registered stages.
// Optional build macro: DMA_PSDP_RAM_WR_BYPASS_EN (write-first forwarding on
// a same-address read/write collision; read-first when undefined).
module dma_psdp_ram_seg_bank
    import dma_ram_pkg::*;
#(
    parameter int SEG_DATA_WIDTH = DEF_SEG_DATA_WIDTH,
    parameter int SEG_ADDR_WIDTH = DEF_SEG_ADDR_WIDTH,
    parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
    parameter int PIPELINE       = 2
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [SEG_BE_WIDTH-1:0]   wr_cmd_be,
    input  logic [SEG_ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic [SEG_DATA_WIDTH-1:0] wr_cmd_data,
    input  logic                      wr_cmd_valid,
    output logic                      wr_cmd_ready,
    output logic                      wr_done,

    input  logic [SEG_ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic                      rd_cmd_valid,
    output logic                      rd_cmd_ready,
    output logic [SEG_DATA_WIDTH-1:0] rd_resp_data,
    output logic                      rd_resp_valid,
    input  logic                      rd_resp_ready
);

    localparam int DEPTH = 2 ** SEG_ADDR_WIDTH;
    localparam int LAST  = PIPELINE - 1;

    logic [SEG_DATA_WIDTH-1:0] mem [DEPTH];

    logic                      ready_reg;
    logic                      wr_fire;
    logic                      rd_fire;
    logic [SEG_DATA_WIDTH-1:0] rd_word;
    logic [PIPELINE-1:0]       adv;
    logic [PIPELINE-1:0]       vld_p;
    logic [SEG_DATA_WIDTH-1:0] data_p [PIPELINE];

`ifdef DMA_PSDP_RAM_WR_BYPASS_EN
    // Replace each enabled byte of the stored word with the incoming write byte.
    function automatic logic [SEG_DATA_WIDTH-1:0] bypass_merge(
        input logic [SEG_DATA_WIDTH-1:0] old_word,
        input logic [SEG_DATA_WIDTH-1:0] new_word,
        input logic [SEG_BE_WIDTH-1:0]   be
    );
        logic [SEG_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < SEG_BE_WIDTH; i++) begin
            if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction
`endif

    assign wr_cmd_ready  = ready_reg;
    assign wr_fire       = wr_cmd_valid && ready_reg;
    assign rd_cmd_ready  = adv[0];
    assign rd_fire       = rd_cmd_valid && adv[0];
    assign rd_resp_data  = data_p[LAST];
    assign rd_resp_valid = vld_p[LAST];

    // Write ready is held low through reset; the done pulse trails each accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_reg <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            wr_done   <= wr_fire;
        end
    end

    // Byte-enabled write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SEG_BE_WIDTH; i++) begin
            if (wr_fire && wr_cmd_be[i]) mem[wr_cmd_addr][i*8 +: 8] <= wr_cmd_data[i*8 +: 8];
        end
    end

    // Stage k may load when the response is taken or any stage from k to the
    // output is empty (closed form of the ripple "empty or next advances").
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        for (int k = LAST; k >= 0; k--) begin
            all_full = all_full && vld_p[k];
            adv[k]   = rd_resp_ready || !all_full;
        end
    end

    // Array read word, optionally with same-cycle write forwarding.
    always_comb begin
        rd_word = mem[rd_cmd_addr];
`ifdef DMA_PSDP_RAM_WR_BYPASS_EN
        if (wr_fire && (wr_cmd_addr == rd_cmd_addr)) begin
            rd_word = bypass_merge(rd_word, wr_cmd_data, wr_cmd_be);
        end
`endif
    end

    // Read pipeline: stage 0 is the SRAM read register, stages 1..LAST are output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPELINE; k++) begin
                vld_p[k]  <= 1'b0;
                data_p[k] <= '0;
            end
        end else begin
            // stage 0: SRAM read
            if (adv[0]) begin
                vld_p[0] <= rd_fire;
                if (rd_fire) data_p[0] <= rd_word;
            end
            // stages 1..LAST: output registers
            for (int k = 1; k < PIPELINE; k++) begin
                if (adv[k]) begin
                    vld_p[k]  <= vld_p[k-1];
                    data_p[k] <= data_p[k-1];
                end
            end
        end
    end

endmodule

// File: rtl/dma_psdp_ram_seg.sv
// Segmented simple-dual-port RAM fed by the PCIe DMA read engine. Each segment
// is an independent bank; this level only slices the flat buses per segment.
// Optional build macro: DMA_PSDP_RAM_WR_BYPASS_EN (see the bank file).
module dma_psdp_ram_seg
    import dma_ram_pkg::*;
#(
    parameter int SEG_COUNT      = DEF_SEG_COUNT,
    parameter int SEG_DATA_WIDTH = DEF_SEG_DATA_WIDTH,
    parameter int SEG_ADDR_WIDTH = DEF_SEG_ADDR_WIDTH,
    parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
    parameter int PIPELINE       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    dma_psdp_ram_seg_if.slave    bus
);

    // One independent bank per segment.
    for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
        dma_psdp_ram_seg_bank #(
            .SEG_DATA_WIDTH (SEG_DATA_WIDTH),
            .SEG_ADDR_WIDTH (SEG_ADDR_WIDTH),
            .SEG_BE_WIDTH   (SEG_BE_WIDTH),
            .PIPELINE       (PIPELINE)
        ) u_bank (
            .clk           (clk),
            .rst           (rst),
            .wr_cmd_be     (bus.wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
            .wr_cmd_addr   (bus.wr_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
            .wr_cmd_data   (bus.wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
            .wr_cmd_valid  (bus.wr_cmd_valid[n]),
            .wr_cmd_ready  (bus.wr_cmd_ready[n]),
            .wr_done       (bus.wr_done[n]),
            .rd_cmd_addr   (bus.rd_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
            .rd_cmd_valid  (bus.rd_cmd_valid[n]),
            .rd_cmd_ready  (bus.rd_cmd_ready[n]),
            .rd_resp_data  (bus.rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
            .rd_resp_valid (bus.rd_resp_valid[n]),
            .rd_resp_ready (bus.rd_resp_ready[n])
        );
    end

endmodule

// File: doc/dma_psdp_ram_seg.md
Name: dma_psdp_ram_seg

Overview:
- Segmented simple-dual-port RAM. Sits directly downstream of the PCIe DMA read engine and consumes its per-segment RAM write commands (sel already decoded upstream).
- Exposes a per-segment pipelined read port for the DMA write engine or for the application.
- Each segment is an independent byte-enabled SRAM bank, SEG_DATA_WIDTH bits wide, with 2**SEG_ADDR_WIDTH words.

Parameters:
SEG_COUNT, 2, number of independent segments/banks
SEG_DATA_WIDTH, 256, data bits per segment word
SEG_ADDR_WIDTH, 12, word-address bits per segment
SEG_BE_WIDTH, SEG_DATA_WIDTH/8, byte enables per segment
PIPELINE, 2, read pipeline depth in cycles (minimum 1)

Ports:
clk  in  1  clock
rst  in  1  reset
wr_cmd_be  in  SEG_COUNT*SEG_BE_WIDTH  per-segment byte enables
wr_cmd_addr  in  SEG_COUNT*SEG_ADDR_WIDTH  per-segment word address
wr_cmd_data  in  SEG_COUNT*SEG_DATA_WIDTH  per-segment write data
wr_cmd_valid  in  SEG_COUNT  per-segment write valid
wr_cmd_ready  out  SEG_COUNT  per-segment write ready
wr_done  out  SEG_COUNT  per-segment write-complete pulse
rd_cmd_addr  in  SEG_COUNT*SEG_ADDR_WIDTH  per-segment read address
rd_cmd_valid  in  SEG_COUNT  per-segment read valid
rd_cmd_ready  out  SEG_COUNT  per-segment read ready
rd_resp_data  out  SEG_COUNT*SEG_DATA_WIDTH  per-segment read data
rd_resp_valid  out  SEG_COUNT  per-segment read data valid
rd_resp_ready  in  SEG_COUNT  per-segment read data ready

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: wr_cmd_ready=0 while rst is high, then 1 from the first cycle after release; wr_done=0; rd_resp_valid=0; all pipeline valid bits=0; rd_resp_data=0. Memory contents are not reset.
- Segments are fully independent. No cross-segment ordering exists and none is required.
- Write path:
  - wr_cmd_ready is constant 1 outside reset.
  - On valid&ready, write each byte i whose be[i]=1 at addr. Bytes with be[i]=0 are unchanged.
  - wr_done[n] pulses high for exactly 1 cycle, 1 cycle after each accepted write on segment n. Back-to-back writes produce back-to-back pulses.
  - A write with be=0 is still accepted and still pulses wr_done.
- Read path:
  - Stage 0 is the SRAM read register. Stages 1..PIPELINE-1 are output registers, each with its own valid bit.
  - A stage advances when it is empty or when the stage after it advances. The last stage advances on rd_resp_ready.
  - rd_cmd_ready = !valid[0] || stage 0 advances (combinational from rd_resp_ready through the valid chain).
  - Latency: PIPELINE cycles from the accept edge to rd_resp_valid, with no stall.
  - Throughput: 1 read per cycle per segment while rd_resp_ready=1.
  - When stalled, data holds stable and valid stays high. No data is dropped or duplicated.
- Collision (same segment, same address, same cycle, read and write both accepted): the read returns old data (read-first).
- Address wrap: addresses are exactly SEG_ADDR_WIDTH bits. No aliasing beyond the modulo.
- Reset mid-operation: in-flight reads are discarded (valids cleared asynchronously). A write accepted on the same edge that rst asserts is not guaranteed.

Optional Feature:
- Macro: DMA_PSDP_RAM_WR_BYPASS_EN.
- Defined: on a same-segment same-address same-cycle collision, each byte with be=1 is forwarded from wr_cmd_data into stage 0 (write-first). Bytes with be=0 return old data.
- Undefined: read-first behaviour as stated in Behaviour. No bypass mux is generated.

Decomposition:
- Package dma_ram_pkg holds:
  - default width localparams: SEG_COUNT, SEG_DATA_WIDTH, SEG_ADDR_WIDTH, SEG_BE_WIDTH;
  - a function computing RAM_ADDR_WIDTH = SEG_ADDR_WIDTH + clog2(SEG_COUNT) + clog2(SEG_BE_WIDTH), shared with the DMA engines.
- Sub-module dma_psdp_ram_seg_bank:
  - one bank containing the memory array, write logic, bypass and read pipeline;
  - instantiated SEG_COUNT times by a generate loop;
  - the top level only slices the buses.

Test Plan:
- Write seg0 addr 0x010 data 0x00..1F pattern be=all-ones; read seg0 0x010 with rd_resp_ready=1 -> wr_done[0] pulse 1 cycle after the write; rd_resp_valid[0] exactly PIPELINE=2 cycles after the read accept, with the same pattern.
- Partial write be=0x0000000F of 0xAA over prior 0x55-filled word -> read returns bytes 0..3=0xAA, remaining bytes 0x55; a be=0 write still pulses wr_done.
- Issue 8 consecutive reads on seg1 with rd_resp_ready toggling 1,0,0,1 -> all 8 responses in order, none lost or duplicated; data stable during stall; rd_cmd_ready drops only when the pipe is full.
- Same cycle on seg0 addr 0x3FF: write 0xBB with all bytes enabled, read of old value 0x11 -> response 0x11 without DMA_PSDP_RAM_WR_BYPASS_EN, 0xBB with it.
- Simultaneous traffic: seg0 writes and seg1 reads, each at 1 per cycle for 16 cycles -> no interaction; addr 0xFFF followed by addr 0x000 accesses distinct words.
- Assert rst with 2 reads in flight -> rd_resp_valid=0 and wr_cmd_ready=0 immediately (asynchronous); after release wr_cmd_ready=1 next cycle and no stale response appears.
